// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Purpose  : Packs decoded instruction fields into 32-bit RV64 I/S/B words,
//            range-checks the immediate, tags each word with a byte address
//            and holds one output word behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [63:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [63:0]       out_addr,
    output logic              err,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [1:0]  c_fmt_i  = 2'b00;
    localparam logic [1:0]  c_fmt_s  = 2'b01;
    localparam logic [1:0]  c_fmt_b  = 2'b11;
    localparam logic [63:0] c_step   = 64'd4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_out_inst;
    logic [63:0]        r_out_addr;
    logic [63:0]        r_addr_cnt;
    logic               r_err;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_accept;
    logic               w_imm12_ok;
    logic               w_imm13_ok;
    logic               w_legal;
    logic [31:0]        w_inst;
    logic [63:0]        w_addr_base;
    logic [ERR_W-1:0]   w_err_base;

    // A full buffer that drains this cycle frees its slot for a new word.
    assign in_ready  = (r_state == EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready;

    // Sign-extension checks: the bits above the field must all match its MSB.
    assign w_imm12_ok = (&imm[63:11]) || (~|imm[63:11]);
    assign w_imm13_ok = ((&imm[63:12]) || (~|imm[63:12])) && !imm[0];

    // Legality and field packing per format selected by opcode[6:5].
    always_comb begin
        w_legal = 1'b0;
        w_inst  = 32'h0;
        case (opcode[6:5])
            c_fmt_i: begin
                w_legal = w_imm12_ok;
                w_inst  = {imm[11:0], rs1, funct3, rd, opcode};
            end
            c_fmt_s: begin
                w_legal = w_imm12_ok;
                w_inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            c_fmt_b: begin
                w_legal = w_imm13_ok;
                w_inst  = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
            end
            default: begin
                w_legal = 1'b0;
                w_inst  = 32'h0;
            end
        endcase
    end

    // A clear in the same cycle as an accept applies before the accept uses
    // the counters, so the accepted word lands at BASE_ADDR.
    assign w_addr_base = clr ? BASE_ADDR : r_addr_cnt;
    assign w_err_base  = clr ? '0 : r_err_count;

    // Output buffer state, address counter and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_out_inst  <= 32'h0;
            r_out_addr  <= 64'h0;
            r_addr_cnt  <= BASE_ADDR;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err       <= 1'b0;
            r_addr_cnt  <= w_addr_base;
            r_err_count <= w_err_base;
            if (w_accept && w_legal) begin
                r_state    <= FULL;
                r_out_inst <= w_inst;
                r_out_addr <= w_addr_base;
                r_addr_cnt <= w_addr_base + c_step;
            end else begin
                if (w_accept) begin
                    r_err <= 1'b1;
                    if (w_err_base != {ERR_W{1'b1}}) begin
                        r_err_count <= w_err_base + 1'b1;
                    end
                end
                if ((r_state == FULL) && out_ready) begin
                    r_state <= EMPTY;
                end
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_inst  = r_out_inst;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
